uart_core_p: RTL

UART_CORE_P -- requirements
Module: uart_core_p

---
 rtl/uart_core_p.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_core_p.sv
// UART core: baud tick generator, show-ahead Tx/Rx FIFOs and Tx/Rx framing FSMs.
// Line loopbacks let firmware test the core with or without the external pins.

module uart_core_p_fifo #(
   parameter int unsigned AW = 4,
   parameter int unsigned W  = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         re_i,
   output logic [W-1:0] rd_data_o,
   output logic [AW:0]  occ_o,
   output logic         ovf_o
);
   localparam int unsigned DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic         ovf_q;
   logic         ne, full, pop, push;

   // Extra pointer bit distinguishes full from empty.
   assign occ_o     = wr_ptr_q - rd_ptr_q;
   assign ne        = (occ_o != '0);
   assign full      = (occ_o == FULL_OCC);
   assign pop       = re_i & ne;
   assign push      = we_i & (~full | pop);
   assign rd_data_o = ne ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   assign ovf_o     = ovf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         ovf_q <= we_i & full & ~pop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end
endmodule

module uart_core_p #(
   parameter int unsigned DIV_W = 12,
   parameter int unsigned TX_AW = 4,
   parameter int unsigned RX_AW = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [1:0]       cfg_bits,
   input  logic [1:0]       cfg_par,
   input  logic             cfg_stop2,
   input  logic             diag_loop,
   input  logic             line_loop,
   input  logic             tx_we,
   input  logic [7:0]       tx_wr_data,
   output logic             tx_full,
   output logic             tx_ovf,
   input  logic             rx_re,
   output logic [10:0]      rx_rd_data,
   output logic             rx_ne,
   output logic             rx_ovf,
   output logic             tx_busy,
   input  logic             uart_rx,
   output logic             uart_tx
);
   localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(1 << TX_AW);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HI} rx_state_e;

   logic [DIV_W-1:0] div_cnt_q;
   logic             tick;

   // Oversample tick: one pulse every baud_div+1 clocks.
   assign tick = (div_cnt_q == '0);
   always_ff @(posedge clk) begin
      if (reset || tick) div_cnt_q <= baud_div;
      else               div_cnt_q <= div_cnt_q - DIV_W'(1);
   end

   logic [TX_AW:0] tx_occ;
   logic [7:0]     tx_fifo_data;
   logic           tx_ne, tx_pop;
   logic [RX_AW:0] rx_occ;
   logic           rx_push;
   logic [10:0]    rx_word;

   uart_core_p_fifo #(.AW(TX_AW), .W(8)) u_tx_fifo (
      .clk(clk), .reset(reset), .we_i(tx_we), .wr_data_i(tx_wr_data), .re_i(tx_pop),
      .rd_data_o(tx_fifo_data), .occ_o(tx_occ), .ovf_o(tx_ovf));

   uart_core_p_fifo #(.AW(RX_AW), .W(11)) u_rx_fifo (
      .clk(clk), .reset(reset), .we_i(rx_push), .wr_data_i(rx_word), .re_i(rx_re),
      .rd_data_o(rx_rd_data), .occ_o(rx_occ), .ovf_o(rx_ovf));

   assign tx_ne   = (tx_occ != '0);
   assign tx_full = (tx_occ == TX_FULL);
   assign rx_ne   = (rx_occ != '0);

   tx_state_e  tx_state_q, tx_state_d;
   logic [3:0] tx_tcnt_q, tx_tcnt_d;
   logic [2:0] tx_bit_q, tx_bit_d, tx_last_q, tx_last_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic       tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
   logic       tx_stop2_q, tx_stop2_d, tx_line_q, tx_line_d, tx_busy_q;
   logic       tx_end;
   logic [7:0] tx_mask;

   assign tx_end  = tick & (tx_tcnt_q == 4'hF);
   assign tx_mask = 8'hFF >> (2'd3 - cfg_bits);

   always_comb begin
      tx_state_d   = tx_state_q;
      tx_tcnt_d    = tx_tcnt_q;
      tx_bit_d     = tx_bit_q;
      tx_sh_d      = tx_sh_q;
      tx_last_d    = tx_last_q;
      tx_par_en_d  = tx_par_en_q;
      tx_par_bit_d = tx_par_bit_q;
      tx_stop2_d   = tx_stop2_q;
      tx_pop       = 1'b0;
      tx_line_d    = 1'b1;
      if (tx_state_q != TX_IDLE && tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
      case (tx_state_q)
         TX_IDLE: if (tick && tx_ne) begin
            // Frame format is captured here so later cfg changes wait for the next frame.
            tx_pop       = 1'b1;
            tx_sh_d      = tx_fifo_data;
            tx_last_d    = 3'd4 + {1'b0, cfg_bits};
            tx_par_en_d  = (cfg_par == 2'd1) || (cfg_par == 2'd2);
            tx_par_bit_d = (^(tx_fifo_data & tx_mask)) ^ (cfg_par == 2'd2);
            tx_stop2_d   = cfg_stop2;
            tx_tcnt_d    = 4'd0;
            tx_state_d   = TX_START;
         end
         TX_START: if (tx_end) begin
            tx_bit_d   = 3'd0;
            tx_state_d = TX_DATA;
         end
         TX_DATA: if (tx_end) begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == tx_last_q) begin
               tx_bit_d   = 3'd0;
               tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
            end
         end
         TX_PARITY: if (tx_end) begin
            tx_bit_d   = 3'd0;
            tx_state_d = TX_STOP;
         end
         TX_STOP: if (tx_end) begin
            if (tx_stop2_q && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
            else                                tx_state_d = TX_IDLE;
         end
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START:  tx_line_d = 1'b0;
         TX_DATA:   tx_line_d = tx_sh_d[0];
         TX_PARITY: tx_line_d = tx_par_bit_d;
         default:   tx_line_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q   <= TX_IDLE;
         tx_tcnt_q    <= '0;
         tx_bit_q     <= '0;
         tx_sh_q      <= '0;
         tx_last_q    <= '0;
         tx_par_en_q  <= 1'b0;
         tx_par_bit_q <= 1'b0;
         tx_stop2_q   <= 1'b0;
         tx_line_q    <= 1'b1;
         tx_busy_q    <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_tcnt_q    <= tx_tcnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_sh_q      <= tx_sh_d;
         tx_last_q    <= tx_last_d;
         tx_par_en_q  <= tx_par_en_d;
         tx_par_bit_q <= tx_par_bit_d;
         tx_stop2_q   <= tx_stop2_d;
         tx_line_q    <= tx_line_d;
         tx_busy_q    <= (tx_state_d != TX_IDLE);
      end
   end

   assign tx_busy = tx_busy_q;
   assign uart_tx = line_loop ? uart_rx : tx_line_q;

   rx_state_e  rx_state_q, rx_state_d;
   logic       rx_s1_q, rx_s2_q;
   logic [3:0] rx_tcnt_q, rx_tcnt_d;
   logic [2:0] rx_bit_q, rx_bit_d, rx_last_q, rx_last_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
   logic       rx_par_err_q, rx_par_err_d, rx_one_q, rx_one_d;
   logic       rx_mid;

   assign rx_mid = tick & (rx_tcnt_q == 4'hF);

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_tcnt_d    = rx_tcnt_q;
      rx_bit_d     = rx_bit_q;
      rx_last_d    = rx_last_q;
      rx_data_d    = rx_data_q;
      rx_par_en_d  = rx_par_en_q;
      rx_odd_d     = rx_odd_q;
      rx_par_err_d = rx_par_err_q;
      rx_one_d     = rx_one_q;
      rx_push      = 1'b0;
      rx_word      = '0;
      if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_HI && tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
      case (rx_state_q)
         RX_IDLE: if (!rx_s2_q) begin
            rx_tcnt_d    = 4'd0;
            rx_bit_d     = 3'd0;
            rx_data_d    = '0;
            rx_last_d    = 3'd4 + {1'b0, cfg_bits};
            rx_par_en_d  = (cfg_par == 2'd1) || (cfg_par == 2'd2);
            rx_odd_d     = (cfg_par == 2'd2);
            rx_par_err_d = 1'b0;
            rx_one_d     = 1'b0;
            rx_state_d   = RX_START;
         end
         // Mid-start sample: a line already back high was only a glitch.
         RX_START: if (tick && rx_tcnt_q == 4'd7) begin
            rx_tcnt_d  = 4'd0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_mid) begin
            rx_data_d[rx_bit_q] = rx_s2_q;
            rx_one_d = rx_one_q | rx_s2_q;
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == rx_last_q) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: if (rx_mid) begin
            rx_par_err_d = rx_s2_q ^ (^rx_data_q) ^ rx_odd_q;
            rx_one_d     = rx_one_q | rx_s2_q;
            rx_state_d   = RX_STOP;
         end
         RX_STOP: if (rx_mid) begin
            rx_push    = 1'b1;
            rx_word    = {~rx_one_q & ~rx_s2_q, rx_par_err_q, ~rx_s2_q, rx_data_q};
            rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT_HI;
         end
         RX_WAIT_HI: if (rx_s2_q) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_tcnt_q    <= '0;
         rx_bit_q     <= '0;
         rx_last_q    <= '0;
         rx_data_q    <= '0;
         rx_par_en_q  <= 1'b0;
         rx_odd_q     <= 1'b0;
         rx_par_err_q <= 1'b0;
         rx_one_q     <= 1'b0;
      end else begin
         rx_s1_q      <= diag_loop ? tx_line_q : uart_rx;
         rx_s2_q      <= rx_s1_q;
         rx_state_q   <= rx_state_d;
         rx_tcnt_q    <= rx_tcnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_last_q    <= rx_last_d;
         rx_data_q    <= rx_data_d;
         rx_par_en_q  <= rx_par_en_d;
         rx_odd_q     <= rx_odd_d;
         rx_par_err_q <= rx_par_err_d;
         rx_one_q     <= rx_one_d;
      end
   end
endmodule
